// File: rtl/xbar_scheduler.sv
// ---------------------------------------------------------------------------
// xbar_scheduler
//
// Per-cycle crossbar scheduler between four input buffers and four output
// buffers. Each output runs its own round-robin arbiter over the inputs whose
// head packet targets it. An output only grants when its buffer has room and
// it is enabled. Grants are registered. They drive the input-buffer read
// strobes and the crossbar source select / write valid for each output.
//
// Ports:
//   clock      in   system clock
//   reset_n    in   asynchronous active-low reset
//   req        in   [3:0]      input i has a head packet
//   req_dest   in   [3:0][1:0] destination output of input i (valid when req[i])
//   out_ready  in   [3:0]      output o can accept a packet this cycle
//   grant      out  [3:0]      one-cycle read strobe to input i
//   out_valid  out  [3:0]      output o is written this cycle
//   out_src    out  [3:0][1:0] input feeding output o (valid with out_valid[o])
//   stall      out  [3:0]      input i requested last cycle but lost
// ---------------------------------------------------------------------------
module xbar_scheduler #(
    parameter logic [3:0] PORT_EN = 4'b1111,
    parameter logic [1:0] RR_INIT = 2'd0
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic [3:0]      req,
    input  logic [3:0][1:0] req_dest,
    input  logic [3:0]      out_ready,
    output logic [3:0]      grant,
    output logic [3:0]      out_valid,
    output logic [3:0][1:0] out_src,
    output logic [3:0]      stall
);

    logic [3:0]      grant_q,     grant_d;
    logic [3:0]      out_valid_q, out_valid_d;
    logic [3:0][1:0] out_src_q,   out_src_d;
    logic [3:0]      stall_q,     stall_d;
    logic [3:0][1:0] ptr_q,       ptr_d;

    // cand[o][i]: input i is eligible for output o at this edge.
    logic [3:0][3:0] cand;
    logic [3:0]      win_found;
    logic [3:0][1:0] win_idx;
    logic [1:0]      idx;

    always_comb begin
        cand        = '0;
        win_found   = '0;
        win_idx     = '0;
        idx         = '0;
        grant_d     = '0;
        out_src_d   = out_src_q;
        ptr_d       = ptr_q;

        // The previous grant masks its input for one edge. The buffer is
        // still popping, so its req is stale during that cycle.
        for (int o = 0; o < 4; o++) begin
            for (int i = 0; i < 4; i++) begin
                cand[o][i] = req[i] && (req_dest[i] == 2'(o)) && !grant_q[i]
                             && out_ready[o] && PORT_EN[o];
            end
        end

        // Search starts at ptr[o] and wraps modulo 4. The first candidate wins.
        for (int o = 0; o < 4; o++) begin
            for (int k = 0; k < 4; k++) begin
                idx = ptr_q[o] + 2'(k);
                if (!win_found[o] && cand[o][idx]) begin
                    win_found[o] = 1'b1;
                    win_idx[o]   = idx;
                end
            end
        end

        // An input has a single destination, so grants from different
        // outputs never collide on the same input.
        for (int o = 0; o < 4; o++) begin
            if (win_found[o]) begin
                grant_d[win_idx[o]] = 1'b1;
                out_src_d[o]        = win_idx[o];
                ptr_d[o]            = win_idx[o] + 2'd1;
            end
        end

        out_valid_d = win_found;
        // A masked input is not counted as stalled.
        stall_d     = req & ~grant_q & ~grant_d;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            grant_q     <= '0;
            out_valid_q <= '0;
            out_src_q   <= '0;
            stall_q     <= '0;
            ptr_q       <= {4{RR_INIT}};
        end else begin
            grant_q     <= grant_d;
            out_valid_q <= out_valid_d;
            out_src_q   <= out_src_d;
            stall_q     <= stall_d;
            ptr_q       <= ptr_d;
        end
    end

    assign grant     = grant_q;
    assign out_valid = out_valid_q;
    assign out_src   = out_src_q;
    assign stall     = stall_q;

endmodule

// File: tb/tb_xbar_scheduler.sv
module tb_xbar_scheduler;

    logic            clock;
    logic            reset_n;
    logic [3:0]      req;
    logic [3:0][1:0] req_dest;
    logic [3:0]      out_ready;
    logic [3:0]      grant,  grant2;
    logic [3:0]      out_valid, out_valid2;
    logic [3:0][1:0] out_src, out_src2;
    logic [3:0]      stall,  stall2;

    int total = 0;
    int bad   = 0;

    xbar_scheduler dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .req       (req),
        .req_dest  (req_dest),
        .out_ready (out_ready),
        .grant     (grant),
        .out_valid (out_valid),
        .out_src   (out_src),
        .stall     (stall)
    );

    // Second instance with output 0 disabled.
    xbar_scheduler #(.PORT_EN(4'b1110), .RR_INIT(2'd0)) dut_pe (
        .clock     (clock),
        .reset_n   (reset_n),
        .req       (req),
        .req_dest  (req_dest),
        .out_ready (out_ready),
        .grant     (grant2),
        .out_valid (out_valid2),
        .out_src   (out_src2),
        .stall     (stall2)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Inputs change at the falling edge; outputs are sampled at the falling
    // edge following the rising edge that produced them.
    task automatic step();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic idle_inputs();
        req       = 4'b0000;
        req_dest  = '0;
        out_ready = 4'hF;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        idle_inputs();
        step();
        step();
        total++;
        if (grant !== 4'b0000) begin
            bad++; $display("FAIL reset_grant got=%b exp=%b", grant, 4'b0000);
        end
        total++;
        if (out_valid !== 4'b0000) begin
            bad++; $display("FAIL reset_out_valid got=%b exp=%b", out_valid, 4'b0000);
        end
        total++;
        if (out_src !== 8'h00) begin
            bad++; $display("FAIL reset_out_src got=%h exp=%h", out_src, 8'h00);
        end
        total++;
        if (stall !== 4'b0000) begin
            bad++; $display("FAIL reset_stall got=%b exp=%b", stall, 4'b0000);
        end
        reset_n = 1'b1;
    endtask

    task automatic test_single();
        req         = 4'b0001;
        req_dest[0] = 2'd2;
        step();
        total++;
        if (grant !== 4'b0001) begin
            bad++; $display("FAIL single_grant got=%b exp=%b", grant, 4'b0001);
        end
        total++;
        if (out_valid !== 4'b0100) begin
            bad++; $display("FAIL single_out_valid got=%b exp=%b", out_valid, 4'b0100);
        end
        total++;
        if (out_src[2] !== 2'd0) begin
            bad++; $display("FAIL single_out_src got=%0d exp=%0d", out_src[2], 0);
        end
        req = 4'b0000;
        step();
        // ptr[2] is now 1: with inputs 0 and 3 both asking for output 2,
        // the search order 1,2,3,0 picks input 3.
        req         = 4'b1001;
        req_dest[0] = 2'd2;
        req_dest[3] = 2'd2;
        step();
        total++;
        if (grant !== 4'b1000) begin
            bad++; $display("FAIL ptr_advance_grant got=%b exp=%b", grant, 4'b1000);
        end
        total++;
        if (out_src[2] !== 2'd3) begin
            bad++; $display("FAIL ptr_advance_src got=%0d exp=%0d", out_src[2], 3);
        end
        total++;
        if (stall !== 4'b0001) begin
            bad++; $display("FAIL ptr_advance_stall got=%b exp=%b", stall, 4'b0001);
        end
        idle_inputs();
        step();
    endtask

    // All four inputs hold requests to output 1. Expected winner order from
    // a pointer of 0 is 0,1,2,3,0,1,2,3; the previous winner is masked and
    // the two remaining losers report stall.
    task automatic run_rr(input string tag);
        logic [3:0] exp_grant;
        logic [3:0] prev_grant;
        logic [3:0] exp_stall;
        req       = 4'hF;
        req_dest  = {2'd1, 2'd1, 2'd1, 2'd1};
        out_ready = 4'hF;
        prev_grant = 4'b0000;
        for (int c = 0; c < 8; c++) begin
            step();
            exp_grant = 4'b0001 << (c % 4);
            exp_stall = 4'hF & ~prev_grant & ~exp_grant;
            total++;
            if (grant !== exp_grant) begin
                bad++; $display("FAIL %s_grant c=%0d got=%b exp=%b", tag, c, grant, exp_grant);
            end
            total++;
            if (out_valid !== 4'b0010) begin
                bad++; $display("FAIL %s_out_valid c=%0d got=%b exp=%b", tag, c, out_valid, 4'b0010);
            end
            total++;
            if (out_src[1] !== 2'(c % 4)) begin
                bad++; $display("FAIL %s_out_src c=%0d got=%0d exp=%0d", tag, c, out_src[1], c % 4);
            end
            total++;
            if (stall !== exp_stall) begin
                bad++; $display("FAIL %s_stall c=%0d got=%b exp=%b", tag, c, stall, exp_stall);
            end
            prev_grant = exp_grant;
        end
        idle_inputs();
        step();
        step();
    endtask

    task automatic test_round_robin();
        test_reset();
        run_rr("rr");
    endtask

    task automatic test_full_permutation();
        req       = 4'hF;
        req_dest  = {2'd0, 2'd1, 2'd2, 2'd3};  // input3->0, input2->1, input1->2, input0->3
        out_ready = 4'hF;
        step();
        total++;
        if (grant !== 4'hF) begin
            bad++; $display("FAIL perm_grant got=%b exp=%b", grant, 4'hF);
        end
        total++;
        if (out_valid !== 4'hF) begin
            bad++; $display("FAIL perm_out_valid got=%b exp=%b", out_valid, 4'hF);
        end
        total++;
        if (out_src !== {2'd0, 2'd1, 2'd2, 2'd3}) begin
            bad++; $display("FAIL perm_out_src got=%h exp=%h", out_src, 8'h1B);
        end
        idle_inputs();
        step();
    endtask

    task automatic test_out_ready_block();
        req         = 4'b0100;
        req_dest[2] = 2'd0;
        out_ready   = 4'b1110;
        for (int c = 0; c < 3; c++) begin
            step();
            total++;
            if (grant !== 4'b0000) begin
                bad++; $display("FAIL block_grant c=%0d got=%b exp=%b", c, grant, 4'b0000);
            end
            total++;
            if (stall !== 4'b0100) begin
                bad++; $display("FAIL block_stall c=%0d got=%b exp=%b", c, stall, 4'b0100);
            end
            total++;
            if (out_valid[0] !== 1'b0) begin
                bad++; $display("FAIL block_out_valid c=%0d got=%b exp=%b", c, out_valid[0], 1'b0);
            end
        end
        out_ready = 4'hF;
        step();
        total++;
        if (grant !== 4'b0100) begin
            bad++; $display("FAIL unblock_grant got=%b exp=%b", grant, 4'b0100);
        end
        total++;
        if (stall !== 4'b0000) begin
            bad++; $display("FAIL unblock_stall got=%b exp=%b", stall, 4'b0000);
        end
        total++;
        if (out_src[0] !== 2'd2) begin
            bad++; $display("FAIL unblock_out_src got=%0d exp=%0d", out_src[0], 2);
        end
        idle_inputs();
        step();
    endtask

    task automatic test_port_disable();
        req         = 4'b0010;
        req_dest[1] = 2'd0;
        out_ready   = 4'hF;
        for (int c = 0; c < 4; c++) begin
            step();
            total++;
            if (out_valid2 !== 4'b0000) begin
                bad++; $display("FAIL pe_out_valid c=%0d got=%b exp=%b", c, out_valid2, 4'b0000);
            end
            total++;
            if (stall2 !== 4'b0010) begin
                bad++; $display("FAIL pe_stall c=%0d got=%b exp=%b", c, stall2, 4'b0010);
            end
            total++;
            if (grant2 !== 4'b0000) begin
                bad++; $display("FAIL pe_grant c=%0d got=%b exp=%b", c, grant2, 4'b0000);
            end
        end
        idle_inputs();
        step();
        step();
    endtask

    task automatic test_reset_mid();
        test_reset();
        // Inputs 0 and 2 to output 0 (pointer 0 -> input 0 wins), input 1 to
        // output 1. Expect grant 0011 with input 2 stalled.
        req       = 4'b0111;
        req_dest  = {2'd0, 2'd0, 2'd1, 2'd0};
        out_ready = 4'hF;
        step();
        total++;
        if (grant !== 4'b0011) begin
            bad++; $display("FAIL mid_pre_grant got=%b exp=%b", grant, 4'b0011);
        end
        total++;
        if (stall !== 4'b0100) begin
            bad++; $display("FAIL mid_pre_stall got=%b exp=%b", stall, 4'b0100);
        end
        #2;
        reset_n = 1'b0;
        #1;
        total++;
        if (grant !== 4'b0000) begin
            bad++; $display("FAIL mid_async_grant got=%b exp=%b", grant, 4'b0000);
        end
        total++;
        if (out_valid !== 4'b0000) begin
            bad++; $display("FAIL mid_async_out_valid got=%b exp=%b", out_valid, 4'b0000);
        end
        total++;
        if (stall !== 4'b0000) begin
            bad++; $display("FAIL mid_async_stall got=%b exp=%b", stall, 4'b0000);
        end
        total++;
        if (out_src !== 8'h00) begin
            bad++; $display("FAIL mid_async_out_src got=%h exp=%h", out_src, 8'h00);
        end
        idle_inputs();
        @(negedge clock);
        reset_n = 1'b1;
        run_rr("rr_after_reset");
    endtask

    initial begin
        reset_n = 1'b0;
        idle_inputs();
        test_reset();
        test_single();
        test_round_robin();
        test_full_permutation();
        test_out_ready_block();
        test_port_disable();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Hard stop in case the sequence above ever stalls.
    initial begin
        #100000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
